// File: rtl/ex_pc_sequencer.sv
// rtl/ex_pc_sequencer.sv - PC owner and single-issue fetch/execute sequencer for the B-type core
// Optional BRANCH_STATS_EN adds saturating branch total/taken counters.
module ex_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  input  logic        is_branch_i,
  input  logic        ex_branch_i,
  input  logic [31:0] pc_branch_i,
  input  logic        stall_i,
`ifdef BRANCH_STATS_EN
  output logic [31:0] br_total_o,
  output logic [31:0] br_taken_o,
`endif
  output logic        trap_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr, instr_next;
  logic        trap, trap_next;
  logic        taken, aligned, retire;

  assign taken   = is_branch_i & ex_branch_i;
  assign aligned = (pc_branch_i[1:0] == 2'b00);
  assign retire  = (state == EXEC) & ~stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= NOP;
      trap  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
      trap  <= trap_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    trap_next  = trap;
    case (state)
      FETCH: begin
        if (imem_rvalid) begin
          instr_next = imem_rdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!stall_i) begin
          if (taken && aligned) begin
            pc_next    = pc_branch_i;
            state_next = FETCH;
          end else if (taken) begin
            trap_next  = 1'b1;
            state_next = TRAP;
          end else begin
            pc_next    = pc + 32'd4;
            state_next = FETCH;
          end
        end
      end
      TRAP: state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  // Request is masked while rst is high so nothing is issued in the reset cycle.
  assign imem_req      = (state == FETCH) & ~rst;
  assign imem_addr     = imem_req ? pc : 32'h0;
  assign instr_valid_o = (state == EXEC);
  assign instr_o       = instr;
  assign pc_o          = pc;
  assign trap_o        = trap;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_total, br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_total <= 32'h0;
      br_taken <= 32'h0;
    end else if (retire && is_branch_i) begin
      if (br_total != 32'hFFFF_FFFF) br_total <= br_total + 32'd1;
      if (taken && aligned && br_taken != 32'hFFFF_FFFF) br_taken <= br_taken + 32'd1;
    end
  end

  assign br_total_o = br_total;
  assign br_taken_o = br_taken;
`endif

endmodule

// File: tb/tb_ex_pc_sequencer.sv
// tb/tb_ex_pc_sequencer.sv - directed plus randomized bench with a per-instruction reference model
// Stats checks are compiled in when BRANCH_STATS_EN is defined.
module tb_ex_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic        is_branch_i;
  logic        ex_branch_i;
  logic [31:0] pc_branch_i;
  logic        stall_i;
  logic        trap_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_o, br_taken_o;
`endif

  ex_pc_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .pc_o(pc_o),
    .is_branch_i(is_branch_i), .ex_branch_i(ex_branch_i),
    .pc_branch_i(pc_branch_i), .stall_i(stall_i),
`ifdef BRANCH_STATS_EN
    .br_total_o(br_total_o), .br_taken_o(br_taken_o),
`endif
    .trap_o(trap_o)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: where the next fetch must go, and branch tallies.
  logic [31:0] exp_pc;
  logic        exp_trap;
  int          exp_total, exp_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef BRANCH_STATS_EN
    check("br_total", br_total_o, exp_total);
    check("br_taken", br_taken_o, exp_taken);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_rvalid = 1'b0;
    step();
    step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc", pc_o, RPC);
    check("rst_instr", instr_o, NOP);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_trap", {31'b0, trap_o}, 32'd0);
    rst = 1'b0;
    step();
    exp_pc = RPC; exp_trap = 1'b0; exp_total = 0; exp_taken = 0;
    check_stats();
  endtask

  // One full instruction: 'waits' memory wait cycles, 'stalls' EXEC stall cycles.
  task automatic do_instr(input int waits, input int stalls, input logic br, input logic cond,
                          input logic [31:0] target);
    logic [31:0] data;
    int          start;
    data  = $urandom;
    start = cyc;
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_valid", {31'b0, instr_valid_o}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      step();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, exp_pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    for (int i = 0; i < stalls; i++) begin
      imem_rvalid = $urandom_range(0, 1);
      imem_rdata  = $urandom;
      stall_i     = 1'b1;
      is_branch_i = $urandom_range(0, 1);
      ex_branch_i = $urandom_range(0, 1);
      pc_branch_i = $urandom;
      check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_instr", instr_o, data);
      check("stall_pc", pc_o, exp_pc);
      step();
    end
    imem_rvalid = $urandom_range(0, 1);
    imem_rdata  = $urandom;
    stall_i     = 1'b0;
    is_branch_i = br;
    ex_branch_i = cond;
    pc_branch_i = target;
    check("exec_valid", {31'b0, instr_valid_o}, 32'd1);
    check("exec_instr", instr_o, data);
    check("exec_pc", pc_o, exp_pc);
    step();
    imem_rvalid = 1'b0;
    is_branch_i = 1'b0;
    ex_branch_i = 1'b0;
    stall_i     = 1'b0;
    if (br) exp_total++;
    if (br && cond && target[1:0] == 2'b00) begin
      exp_taken++;
      exp_pc = target;
    end else if (br && cond) begin
      exp_trap = 1'b1;
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
    if (!exp_trap) check("cycles", cyc - start, waits + stalls + 2);
    check("trap", {31'b0, trap_o}, {31'b0, exp_trap});
    check("next_pc", pc_o, exp_pc);
    check_stats();
  endtask

  initial begin
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    is_branch_i = 1'b0; ex_branch_i = 1'b0; pc_branch_i = 32'h0; stall_i = 1'b0;
    exp_pc = RPC; exp_trap = 1'b0; exp_total = 0; exp_taken = 0;

    do_reset();
    for (int i = 0; i < 4; i++) do_instr(0, 0, 1'b0, 1'b0, 32'h0);

    do_reset();
    do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    do_instr(0, 0, 1'b1, 1'b1, 32'h0000_00F0);
    check("br_target_addr", imem_addr, 32'h0000_00F0);

    do_instr(0, 0, 1'b1, 1'b1, 32'h0000_0200);
    do_instr(0, 0, 1'b1, 1'b0, 32'h0000_0400);
    check("untaken_addr", imem_addr, 32'h0000_0204);
    do_instr(0, 0, 1'b0, 1'b1, 32'h0000_0800);
    do_instr(3, 2, 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      logic br, cond;
      logic [31:0] tgt;
      br   = $urandom_range(0, 1);
      cond = $urandom_range(0, 1);
      tgt  = {$urandom_range(0, 32'h3FFF), 2'b00};
      do_instr($urandom_range(0, 3), $urandom_range(0, 2), br, cond, tgt);
    end

    do_instr(1, 0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    do_instr(0, 1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    do_instr(0, 0, 1'b1, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 3; i++) begin
      imem_rvalid = 1'b1;
      step();
      check("trap_req", {31'b0, imem_req}, 32'd0);
      check("trap_valid", {31'b0, instr_valid_o}, 32'd0);
      check("trap_hold", {31'b0, trap_o}, 32'd1);
      check("trap_pc", pc_o, exp_pc);
    end
    do_reset();
    check("post_trap_pc", pc_o, RPC);

    do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    imem_rvalid = 1'b0;
    step();
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    check("rst_fetch_instr", instr_o, NOP);
    check("rst_fetch_pc", pc_o, RPC);
    rst = 1'b0;
    imem_rvalid = 1'b0;
    step();
    check("rst_fetch_req", {31'b0, imem_req}, 32'd1);
    check("rst_fetch_addr", imem_addr, RPC);
    check("rst_fetch_nolatch", {31'b0, instr_valid_o}, 32'd0);
    exp_pc = RPC; exp_trap = 1'b0; exp_total = 0; exp_taken = 0;
    do_instr(2, 1, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
